// File: rtl/bcd_time_counter_if.sv
// Control and digit bundle between the time-of-day counter and its neighbours
// (button stage drives the controls; display and chime consume the digits).
interface bcd_time_counter_if;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] Hour_First;
  logic [3:0] Hour_Second;
  logic [3:0] Minute_First;
  logic [3:0] Minute_Second;
  logic [3:0] Second_First;
  logic [3:0] Second_Second;
  logic       sec_pulse;
  logic       hour_pulse;

  modport master (
    output set_mode, inc_min, inc_hour,
    input  Hour_First, Hour_Second, Minute_First, Minute_Second,
    input  Second_First, Second_Second, sec_pulse, hour_pulse
  );

  modport slave (
    input  set_mode, inc_min, inc_hour,
    output Hour_First, Hour_Second, Minute_First, Minute_Second,
    output Second_First, Second_Second, sec_pulse, hour_pulse
  );
endinterface

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, hour wrap in 24 or 12 hour
// format, and a set mode where minutes/hours are bumped by single-cycle pulses.
module bcd_time_counter #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned HOUR_FORMAT = 24
) (
  input logic               clk,
  input logic               rst,
  bcd_time_counter_if.slave bus
);

  localparam int unsigned PW            = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX     = PW'(TICK_DIV - 1);
  localparam logic [7:0]    HOUR_RESET  = (HOUR_FORMAT == 12) ? 8'h12 : 8'h00;

  typedef enum logic [0:0] {StRun, StSet} state_e;

  state_e        state_q;
  logic [PW-1:0] prescaler_q;
  logic [7:0]    hours_q;
  logic [7:0]    minutes_q;
  logic [7:0]    seconds_q;
  logic          sec_pulse_q;
  logic          hour_pulse_q;

  // Two-digit BCD increment modulo 60, shared by seconds and minutes.
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v == 8'h59)         return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (HOUR_FORMAT == 12 && v == 8'h12)      return 8'h01;
    else if (HOUR_FORMAT != 12 && v == 8'h23) return 8'h00;
    else if (v[3:0] == 4'd9)                  return {v[7:4] + 4'd1, 4'd0};
    else                                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      prescaler_q  <= '0;
      hours_q      <= HOUR_RESET;
      minutes_q    <= 8'h00;
      seconds_q    <= 8'h00;
      sec_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      // set_mode takes priority over a prescaler wrap on the same edge.
      if (bus.set_mode) begin
        state_q     <= StSet;
        prescaler_q <= '0;
        if (state_q == StRun) seconds_q <= 8'h00;
        if (bus.inc_min)      minutes_q <= inc_mod60(minutes_q);
        if (bus.inc_hour)     hours_q   <= inc_hour(hours_q);
      end else begin
        state_q <= StRun;
        if (prescaler_q == PRE_MAX) begin
          prescaler_q <= '0;
          sec_pulse_q <= 1'b1;
          seconds_q   <= inc_mod60(seconds_q);
          if (seconds_q == 8'h59) begin
            minutes_q <= inc_mod60(minutes_q);
            if (minutes_q == 8'h59) begin
              hours_q      <= inc_hour(hours_q);
              hour_pulse_q <= 1'b1;
            end
          end
        end else begin
          prescaler_q <= prescaler_q + PW'(1);
        end
      end
    end
  end

  assign bus.Hour_First    = hours_q[7:4];
  assign bus.Hour_Second   = hours_q[3:0];
  assign bus.Minute_First  = minutes_q[7:4];
  assign bus.Minute_Second = minutes_q[3:0];
  assign bus.Second_First  = seconds_q[7:4];
  assign bus.Second_Second = seconds_q[3:0];
  assign bus.sec_pulse     = sec_pulse_q;
  assign bus.hour_pulse    = hour_pulse_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: 24h and 12h instances against a seconds-of-day model,
// plus hand-computed literal expectations along a directed scenario.
module tb_bcd_time_counter;
  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   started = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bcd_time_counter_if b24 ();
  bcd_time_counter_if b12 ();

  bcd_time_counter #(.TICK_DIV(TICK), .HOUR_FORMAT(24)) u_dut24 (.clk(clk), .rst(rst), .bus(b24));
  bcd_time_counter #(.TICK_DIV(TICK), .HOUR_FORMAT(12)) u_dut12 (.clk(clk), .rst(rst), .bus(b12));

  logic [23:0] d24, d12;
  assign d24 = {b24.Hour_First, b24.Hour_Second, b24.Minute_First, b24.Minute_Second,
                b24.Second_First, b24.Second_Second};
  assign d12 = {b12.Hour_First, b12.Hour_Second, b12.Minute_First, b12.Minute_Second,
                b12.Second_First, b12.Second_Second};

  // Model: time as seconds since hour-index 0; 12h display maps index 0 to "12".
  int tot[2];
  int pre[2];
  bit in_set[2];
  bit msp[2];
  bit mhp[2];
  logic sm[2], im[2], ih[2];
  assign sm[0] = b24.set_mode;
  assign im[0] = b24.inc_min;
  assign ih[0] = b24.inc_hour;
  assign sm[1] = b12.set_mode;
  assign im[1] = b12.inc_min;
  assign ih[1] = b12.inc_hour;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      automatic int t = tot[i];
      automatic int p = pre[i];
      automatic int hmod = (i == 0) ? 24 : 12;
      automatic bit s_set = in_set[i];
      automatic bit sp = 1'b0;
      automatic bit hp = 1'b0;
      automatic int m = 0;
      automatic int h = 0;
      if (rst) begin
        t = 0; p = 0; s_set = 1'b0;
      end else if (sm[i]) begin
        if (!s_set) t = t - (t % 60);
        p = 0;
        if (im[i]) begin
          m = (t / 60) % 60;
          t = t + (((m + 1) % 60) - m) * 60;
        end
        if (ih[i]) begin
          h = t / 3600;
          t = t + (((h + 1) % hmod) - h) * 3600;
        end
        s_set = 1'b1;
      end else begin
        s_set = 1'b0;
        if (p == TICK - 1) begin
          p = 0;
          t = (t + 1) % (hmod * 3600);
          sp = 1'b1;
          hp = (t % 3600) == 0;
        end else begin
          p = p + 1;
        end
      end
      tot[i]    <= t;
      pre[i]    <= p;
      in_set[i] <= s_set;
      msp[i]    <= sp;
      mhp[i]    <= hp;
    end
  end

  function automatic logic [25:0] expv(input int t, input int fmt, input bit sp, input bit hp);
    int h, m, s;
    h = t / 3600;
    if (fmt == 12 && h == 0) h = 12;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), sp, hp};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (started) begin
      #1;
      check("cycle_24h", {d24, b24.sec_pulse, b24.hour_pulse}, expv(tot[0], 24, msp[0], mhp[0]));
      check("cycle_12h", {d12, b12.sec_pulse, b12.hour_pulse}, expv(tot[1], 12, msp[1], mhp[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    b24.set_mode = 1'b0; b24.inc_min = 1'b0; b24.inc_hour = 1'b0;
    b12.set_mode = 1'b0; b12.inc_min = 1'b0; b12.inc_hour = 1'b0;
    #1 rst = 1'b1;
    started = 1'b1;
    cyc(2);
    check("reset_24h", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000000, 2'b00});
    check("reset_12h", {d12, b12.sec_pulse, b12.hour_pulse}, {24'h120000, 2'b00});
    rst = 1'b0;

    // First advance TICK cycles after release, then ten seconds after 40 cycles.
    cyc(3);
    check("pre_first_advance", {d24, b24.sec_pulse, 1'b0}, {24'h000000, 2'b00});
    cyc(1);
    check("first_advance", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000001, 2'b10});
    cyc(1);
    check("sec_pulse_one_cycle", {25'd0, b24.sec_pulse}, 26'd0);
    cyc(35);
    check("ten_seconds", {2'b00, d24}, {2'b00, 24'h000010});

    // Set 23:59 by held pulses, then run to the day rollover.
    b24.set_mode = 1'b1; b24.inc_hour = 1'b1;
    cyc(23);
    b24.inc_hour = 1'b0; b24.inc_min = 1'b1;
    cyc(59);
    b24.inc_min = 1'b0;
    check("set_2359", {2'b00, d24}, {2'b00, 24'h235900});
    b24.set_mode = 1'b0;
    cyc(59 * TICK);
    check("run_235959", {2'b00, d24}, {2'b00, 24'h235959});
    cyc(TICK);
    check("day_wrap", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000000, 2'b11});
    cyc(1);
    check("hour_pulse_one_cycle", {24'h0, b24.sec_pulse, b24.hour_pulse}, 26'd0);

    // 12h format: 12 -> 01 in SET, then 12:59:59 -> 01:00:00 by running.
    rst_pulse();
    b12.set_mode = 1'b1;
    cyc(1);
    check("12h_after_reset", {2'b00, d12}, {2'b00, 24'h120000});
    b12.inc_hour = 1'b1;
    cyc(1);
    b12.inc_hour = 1'b0;
    check("12h_inc_to_01", {2'b00, d12}, {2'b00, 24'h010000});
    b12.inc_hour = 1'b1;
    cyc(11);
    b12.inc_hour = 1'b0; b12.inc_min = 1'b1;
    cyc(59);
    b12.inc_min = 1'b0;
    check("12h_set_1259", {2'b00, d12}, {2'b00, 24'h125900});
    b12.set_mode = 1'b0;
    cyc(59 * TICK);
    check("12h_run_125959", {2'b00, d12}, {2'b00, 24'h125959});
    cyc(TICK);
    check("12h_wrap_01", {d12, b12.sec_pulse, b12.hour_pulse}, {24'h010000, 2'b11});

    // SET adjust: no carry from minutes; simultaneous pulses apply independently.
    rst_pulse();
    b24.set_mode = 1'b1; b24.inc_hour = 1'b1;
    cyc(10);
    b24.inc_hour = 1'b0; b24.inc_min = 1'b1;
    cyc(59);
    b24.inc_min = 1'b0;
    check("set_1059", {2'b00, d24}, {2'b00, 24'h105900});
    b24.inc_min = 1'b1;
    cyc(1);
    b24.inc_min = 1'b0;
    check("min_wrap_no_carry", {2'b00, d24}, {2'b00, 24'h100000});
    b24.inc_hour = 1'b1;
    cyc(23);
    b24.inc_hour = 1'b0; b24.inc_min = 1'b1;
    cyc(5);
    b24.inc_min = 1'b0;
    check("set_0905", {2'b00, d24}, {2'b00, 24'h090500});
    b24.inc_min = 1'b1; b24.inc_hour = 1'b1;
    cyc(1);
    b24.inc_min = 1'b0; b24.inc_hour = 1'b0;
    check("both_pulses", {2'b00, d24}, {2'b00, 24'h100600});
    b24.set_mode = 1'b0;

    // Entering SET clears seconds; SET freezes time; SET beats a wrap edge.
    rst_pulse();
    cyc(37 * TICK);
    check("run_000037", {2'b00, d24}, {2'b00, 24'h000037});
    b24.set_mode = 1'b1;
    cyc(1);
    check("set_clears_sec", {2'b00, d24}, {2'b00, 24'h000000});
    cyc(100);
    check("set_frozen", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000000, 2'b00});
    b24.set_mode = 1'b0;
    cyc(TICK - 1);
    b24.set_mode = 1'b1;
    cyc(1);
    check("set_wins_wrap", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000000, 2'b00});

    // Asynchronous reset mid-count at 05:42:17 with prescaler at 2.
    b24.inc_hour = 1'b1;
    cyc(5);
    b24.inc_hour = 1'b0; b24.inc_min = 1'b1;
    cyc(42);
    b24.inc_min = 1'b0; b24.set_mode = 1'b0;
    cyc(17 * TICK);
    check("run_054217", {2'b00, d24}, {2'b00, 24'h054217});
    cyc(2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_24h", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000000, 2'b00});
    check("async_reset_12h", {d12, b12.sec_pulse, b12.hour_pulse}, {24'h120000, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    cyc(TICK - 1);
    check("post_reset_no_advance", {d24, b24.sec_pulse, 1'b0}, {24'h000000, 2'b00});
    cyc(1);
    check("post_reset_advance", {d24, b24.sec_pulse, b24.hour_pulse}, {24'h000001, 2'b10});

    cyc(2);
    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
